// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - shared constants for the RV core front end
//
// PC_SEL      : next-PC select driven into riscv_pc (PC_HOLD keeps the PC).
// FETCH_STATE : instruction-fetch sequencer states used by riscv_fetch_ctrl.
package riscv_constants;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_PLUS4  = 2'b01,
    PC_TARGET = 2'b10
  } PC_SEL;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } FETCH_STATE;

endpackage

// File: rtl/riscv_fetch_ctrl.sv
// rtl/riscv_fetch_ctrl.sv - multi-cycle instruction fetch sequencer
//
// Ports:
//   clk, x_reset                     clock, async active-low reset
//   imem_req / imem_gnt              fetch request (address is riscv_pc pc_out)
//   imem_rvalid / imem_rdata         fetch response
//   inst_valid / inst / inst_ready   held instruction towards decode
//   redirect_valid / redirect_ready  taken branch/jump from execute
//   pc_sel                           next-PC select for riscv_pc (one-cycle pulses)
//   inst_count                       instructions delivered to decode (wraps)
module riscv_fetch_ctrl
  import riscv_constants::*;
(
  input  logic        clk,
  input  logic        x_reset,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  output logic        redirect_ready,
  output PC_SEL       pc_sel,
  output logic [31:0] inst_count
);

  FETCH_STATE state;
  logic       drop;
  logic       xfer;

  assign imem_req = (state == REQ);

  // A pending redirect kills the held instruction, so it is never offered.
  assign inst_valid = (state == HOLD) && !redirect_valid;

  // Redirects are refused in REQ: pc_out is the request address until granted.
  assign redirect_ready = redirect_valid && ((state == WAIT) || (state == HOLD));

  assign xfer = inst_valid && inst_ready;

  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_ready) begin
      pc_sel = PC_TARGET;
    end else if (xfer) begin
      pc_sel = PC_PLUS4;
    end
  end

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state      <= IDLE;
      drop       <= 1'b0;
      inst       <= '0;
      inst_count <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            // Data arriving with a redirect, or after one, belongs to the old path.
            if (!drop && !redirect_valid) begin
              inst  <= imem_rdata;
              state <= HOLD;
            end else begin
              state <= REQ;
            end
            drop <= 1'b0;
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            state <= REQ;
          end else if (inst_ready) begin
            inst_count <= inst_count + 32'd1;
            state      <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// tb/tb_riscv_fetch_ctrl.sv - scoreboard bench for riscv_fetch_ctrl
module tb_riscv_fetch_ctrl;
  import riscv_constants::*;

  logic        clk;
  logic        x_reset;
  logic        imem_req;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        redirect_valid;
  logic        redirect_ready;
  PC_SEL       pc_sel;
  logic [31:0] inst_count;

  logic [31:0] imm;
  logic [31:0] tb_pc;

  int tests = 0;
  int fails = 0;

  // memory responder state
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  int          gnt_wait;
  bit          rsp_pend;
  int          rsp_cnt;
  logic [31:0] rsp_addr;
  bit          rand_mem = 0;
  bit          stray_en = 0;

  // execute / decode drivers
  bit          redir_req;
  logic [31:0] redir_imm;
  bit          redir_rand = 0;
  bit          rdy_rand = 0;
  bit          rdy_val = 0;
  bit          acc_last;

  // reference model: architectural PC and the program it walks
  logic [31:0] ref_pc;
  logic [31:0] model_count;
  logic [31:0] exp_q[$];
  int          idle;
  int          soak_xfers = 0;

  riscv_fetch_ctrl dut (
    .clk            (clk),
    .x_reset        (x_reset),
    .imem_req       (imem_req),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .pc_sel         (pc_sel),
    .inst_count     (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for riscv_pc.
  always @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      tb_pc <= 32'd0;
    end else begin
      case (pc_sel)
        PC_PLUS4:  tb_pc <= tb_pc + 32'd4;
        PC_TARGET: tb_pc <= tb_pc + imm;
        default:   ;
      endcase
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  task automatic reset_env();
    rsp_pend       = 0;
    gnt_wait       = 0;
    redir_req      = 0;
    acc_last       = 0;
    redirect_valid = 0;
    imem_gnt       = 0;
    imem_rvalid    = 0;
    inst_ready     = 0;
    ref_pc         = 32'd0;
    model_count    = 32'd0;
    idle           = 0;
    exp_q.delete();
    exp_q.push_back(mem_word(32'd0));
  endtask

  task automatic apply_reset();
    x_reset = 1'b0;
    reset_env();
    @(negedge clk);
    @(negedge clk);
    x_reset = 1'b1;
  endtask

  task automatic mem_drive();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(rsp_addr);
        rsp_pend    = 0;
      end else begin
        rsp_cnt--;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    if (imem_req) begin
      if (gnt_wait >= gnt_delay) begin
        imem_gnt = 1'b1;
        gnt_wait = 0;
        rsp_pend = 1;
        rsp_cnt  = rsp_delay;
        rsp_addr = tb_pc;
        if (rand_mem) begin
          gnt_delay = $urandom_range(0, 3);
          rsp_delay = $urandom_range(0, 3);
        end
      end else begin
        gnt_wait++;
      end
    end
  endtask

  // Scoreboard: compares the cycle's handshakes, then advances the model.
  task automatic monitor();
    logic  xfer;
    logic  acc;
    PC_SEL exp_sel;
    xfer    = inst_valid && inst_ready;
    acc     = redirect_valid && redirect_ready;
    exp_sel = acc ? PC_TARGET : (xfer ? PC_PLUS4 : PC_HOLD);
    check("pc_sel", 32'(pc_sel), 32'(exp_sel));
    check("inst_count", inst_count, model_count);
    if (redirect_valid) check("valid_masked", 32'(inst_valid), 32'd0);
    if (redirect_ready) check("ready_needs_valid", 32'(redirect_valid), 32'd1);
    if (imem_req) begin
      check("req_addr", tb_pc, ref_pc);
      check("req_no_redirect", 32'(redirect_ready), 32'd0);
    end
    if (xfer) begin
      if (exp_q.size() == 0) fail_now("inst_unexpected");
      else check("inst", inst, exp_q.pop_front());
    end
    if (acc) begin
      ref_pc = ref_pc + imm;
      exp_q.delete();
      exp_q.push_back(mem_word(ref_pc));
      idle = 0;
    end else if (xfer) begin
      ref_pc      = ref_pc + 32'd4;
      model_count = model_count + 32'd1;
      soak_xfers++;
      exp_q.push_back(mem_word(ref_pc));
      idle = 0;
    end else begin
      idle++;
    end
    if (idle > 60) begin
      fail_now("watchdog");
      idle = 0;
    end
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    mem_drive();
    if (redirect_valid && acc_last) redirect_valid = 1'b0;
    if (!redirect_valid) begin
      if (redir_req) begin
        redirect_valid = 1'b1;
        imm            = redir_imm;
        redir_req      = 0;
      end else if (redir_rand && $urandom_range(0, 99) < 12) begin
        redirect_valid = 1'b1;
        imm            = 32'($urandom_range(1, 16)) * 32'd4;
      end
    end
    inst_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    @(negedge clk);
    acc_last = redirect_valid && redirect_ready;
    monitor();
  endtask

  initial begin
    bit          found;
    bit          prev;
    int          n;
    logic [31:0] c;
    logic [31:0] p0;

    x_reset    = 1'b0;
    imem_rdata = 32'd0;
    imm        = 32'd0;
    redir_imm  = 32'd0;
    reset_env();
    repeat (3) @(negedge clk);

    // reset values
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_rready", 32'(redirect_ready), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'(PC_HOLD));
    check("rst_inst", inst, 32'd0);
    check("rst_count", inst_count, 32'd0);
    check("rst_pc", tb_pc, 32'd0);

    // first request, zero-wait memory, decode stall on the first word
    x_reset = 1'b1;
    check("c0_req", 32'(imem_req), 32'd0);
    step();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", tb_pc, 32'd0);
    step();
    step();
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_inst", inst, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_inst", inst, 32'h0000_0013);
      check("stall_sel", 32'(pc_sel), 32'(PC_HOLD));
    end
    rdy_val = 1;
    step();
    check("release_sel", 32'(pc_sel), 32'(PC_PLUS4));
    step();
    check("release_count", inst_count, 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step();
      check("thru_valid", 32'(inst_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
    end
    step();
    check("thru_count", inst_count, 32'd5);

    // redirect in WAIT at pc 8, imm 0x40, response arrives later
    apply_reset();
    gnt_delay = 0;
    rsp_delay = 2;
    rdy_val   = 1;
    found     = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_gnt && tb_pc == 32'd8) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("reach_pc8");
    redir_imm = 32'h40;
    redir_req = 1;
    step();
    check("wait_redir_ready", 32'(redirect_ready), 32'd1);
    check("wait_redir_sel", 32'(pc_sel), 32'(PC_TARGET));
    check("wait_redir_count", inst_count, 32'd2);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req) begin
        found = 1;
        break;
      end
      check("wait_redir_novalid", 32'(inst_valid), 32'd0);
    end
    if (!found) fail_now("wait_redir_rereq");
    check("wait_redir_addr", tb_pc, 32'h48);
    check("wait_redir_count2", inst_count, 32'd2);

    // redirect raised in REQ is held off until the grant
    gnt_delay = 2;
    rsp_delay = 0;
    prev      = imem_req;
    found     = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req && !prev) begin
        found = 1;
        break;
      end
      prev = imem_req;
    end
    if (!found) fail_now("reach_req");
    redir_imm = 32'h8;
    redir_req = 1;
    found     = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (redirect_ready) begin
        check("req_redir_acc_state", 32'(imem_req), 32'd0);
        found = 1;
        break;
      end
      check("req_redir_held", 32'(imem_req), 32'd1);
    end
    if (!found) fail_now("req_redir_accept");

    // redirect together with inst_ready in HOLD
    gnt_delay = 0;
    found     = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_gnt) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("hold_gnt");
    step();
    redir_imm = 32'h10;
    redir_req = 1;
    step();
    check("hold_redir_valid", 32'(inst_valid), 32'd0);
    check("hold_redir_sel", 32'(pc_sel), 32'(PC_TARGET));
    c = inst_count;
    step();
    check("hold_redir_count", inst_count, c);

    // grant delayed three cycles
    gnt_delay = 3;
    prev      = imem_req;
    found     = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req && !prev) begin
        found = 1;
        break;
      end
      prev = imem_req;
    end
    if (!found) fail_now("gnt_delay_req");
    p0 = tb_pc;
    n  = 1;
    for (int i = 0; i < 10 && !imem_gnt; i++) begin
      step();
      n++;
      check("gnt_delay_req_held", 32'(imem_req), 32'd1);
      check("gnt_delay_pc", tb_pc, p0);
    end
    check("gnt_delay_cycles", 32'(n), 32'd4);

    // reset while a response is outstanding
    gnt_delay = 0;
    rsp_delay = 3;
    found     = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_gnt) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("midrst_gnt");
    step();
    x_reset = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_rready", 32'(redirect_ready), 32'd0);
    check("midrst_sel", 32'(pc_sel), 32'(PC_HOLD));
    check("midrst_inst", inst, 32'd0);
    check("midrst_count", inst_count, 32'd0);
    check("midrst_pc", tb_pc, 32'd0);
    reset_env();
    rsp_delay = 0;
    @(negedge clk);
    @(negedge clk);
    x_reset     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    check("midrst_first_req", 32'(imem_req), 32'd1);
    check("midrst_first_addr", tb_pc, 32'd0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inst_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("midrst_valid_seen");
    check("midrst_first_inst", inst, 32'h0000_0013);

    // randomized soak
    rand_mem   = 1;
    redir_rand = 1;
    rdy_rand   = 1;
    stray_en   = 1;
    soak_xfers = 0;
    repeat (3000) step();
    check("soak_progress", 32'(soak_xfers > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_ctrl.md
# riscv_fetch_ctrl

Multi-cycle instruction-fetch sequencer that drives the `pc_sel` input of `riscv_pc` and runs the request/grant/response handshake to instruction memory. It holds each fetched instruction for decode under a valid/ready handshake and applies branch/jump redirects from execute. The block sits between `riscv_pc`, the instruction memory port and the decode stage. The PC is advanced only when an instruction is consumed or a redirect is accepted.

## Interface

- No parameters. Data width is 32 bits; the `PC_SEL` type comes from the shared constants package.
- `clk` in 1: single clock; all state updates on its rising edge.
- `x_reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request; address is `pc_out` from `riscv_pc`.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: fetched instruction word.
- `inst_valid` out 1: held instruction available to decode.
- `inst` out 32: held instruction.
- `inst_ready` in 1: decode consumes `inst` this cycle.
- `redirect_valid` in 1: execute requests the PC go to the taken target (PC + `imm_i_sext`).
- `redirect_ready` out 1: redirect accepted this cycle.
- `pc_sel` out `PC_SEL`: `PC_HOLD`, `PC_PLUS4` or `PC_TARGET`; combinational, one-cycle pulses.
- `inst_count` out 32: number of instructions delivered to decode; wraps modulo 2^32.

## Operation

- **States:** IDLE, REQ, WAIT, HOLD. Register `drop` marks a response to be discarded.
- **IDLE:**
  - Entered on reset.
  - Goes to REQ unconditionally on the next clock.
- **REQ:**
  - `imem_req`=1.
  - On `imem_gnt`, go to WAIT.
  - `redirect_ready`=0 here, because the address must stay stable until grant.
- **WAIT:**
  - On `imem_rvalid` with `drop`=0: capture `imem_rdata` into `inst` and go to HOLD.
  - On `imem_rvalid` with `drop`=1: discard the data, clear `drop` and go to REQ.
  - A redirect in WAIT is accepted: `pc_sel`=`PC_TARGET` and `drop`←1.
  - If `redirect_valid` and `imem_rvalid` occur in the same cycle, the data is discarded, the redirect is applied and the next state is REQ.
- **HOLD:**
  - `inst_valid` = (state==HOLD) && !`redirect_valid`.
  - On a transfer (`inst_valid` && `inst_ready`): `pc_sel`=`PC_PLUS4`, `inst_count`+1, go to REQ.
  - A redirect in HOLD has priority over `inst_ready`: `pc_sel`=`PC_TARGET`, the held instruction is killed (no transfer, no count), go to REQ.
- **Redirect handshake:** `redirect_ready` = `redirect_valid` && state∈{WAIT, HOLD}. At most one redirect is accepted per cycle. In IDLE and REQ the redirect must be held by execute until accepted.
- **PC select:** `pc_sel`=`PC_HOLD` in every cycle without a transfer or an accepted redirect. `riscv_pc` therefore updates at most once per fetched instruction.
- **Stray responses:** `imem_rvalid` outside WAIT is ignored. The memory must be reset together with this block.

## Timing

- **Reset values:**
  - state=IDLE, `drop`=0, `inst`=0, `inst_count`=0.
  - `imem_req`=0, `inst_valid`=0, `redirect_ready`=0, `pc_sel`=`PC_HOLD`.
  - PC in `riscv_pc` is 0.
- **Reset mid-operation:** everything returns to the reset values immediately. Any outstanding request is abandoned and `drop` is cleared.
- **First request:** `imem_req` is first asserted in cycle 1 after reset release, for address 0.
- **Zero-wait memory (`gnt` in REQ, `rvalid` the next cycle):**
  - `inst_valid` rises 2 cycles after REQ entry.
  - With `inst_ready` tied high, the sustained throughput is 1 instruction per 3 cycles (REQ→WAIT→HOLD).
- **PC update:** the PC changes on the clock edge ending the cycle in which `pc_sel`≠`PC_HOLD`. The next REQ therefore sees the updated `pc_out`.
- **Output types:** `inst_valid`, `redirect_ready` and `pc_sel` are combinational from state and inputs. `imem_req` is decoded from state only.

## Structure

- **Shared package:** `PC_SEL` gains `PC_HOLD` (encoding 2'b00) alongside `PC_PLUS4` and `PC_TARGET`. Add a `FETCH_STATE` enum (IDLE, REQ, WAIT, HOLD). Both live in `riscv_constants`.
- **Sub-modules:** none needed. The block instantiates nothing; it and `riscv_pc` are connected side by side in the core top.

## Test plan

- **Reset, zero-wait memory, `inst_ready`=1:** `pc_out` sequence 0,4,8,12. `inst_valid` pulses every 3 cycles; after 4 pulses `inst_count`=4.
- **Decode stall:** `inst_ready`=0 for 5 cycles in HOLD, returning 0x00000013. `inst` and `inst_valid` stay stable and `pc_sel`=`PC_HOLD` throughout. On release: one `PC_PLUS4` pulse and `inst_count`+1.
- **Redirect in WAIT, imm=0x40 at pc=8:** `pc_sel`=`PC_TARGET`. The next response is discarded with no `inst_valid`. The next request is for address 0x48 and `inst_count` is unchanged.
- **Redirect and `inst_ready` together in HOLD:** `inst_valid`=0 that cycle, `pc_sel`=`PC_TARGET`, no count. Also apply a redirect in REQ: `redirect_ready` stays 0 until `imem_gnt`, then is accepted in WAIT.
- **`imem_gnt` delayed 3 cycles:** `imem_req` is held high for 4 cycles and `pc_out` stays constant during the wait.
- **`x_reset` low while in WAIT:** all outputs return to their reset values asynchronously. A later stray `imem_rvalid` is ignored and the first post-reset request is for address 0.
